mavg3_window: RTL and testbench

//  Sliding 3-sample window accumulator feeding the combinational divide-by-3 stage.
//  - Accepts a stream of unsigned samples.
//  - Once 3 samples are held, emits their 16-bit sum for every new sample.
//  - The downstream div_by_3 turns that sum into a 3-tap moving average.
//  - Valid/ready on both sides; one output register stage.

---
 rtl/mavg3_window_if.sv | 32 +++
 rtl/mavg3_window.sv | 104 ++++++++++
 tb/tb_mavg3_window.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mavg3_window_if.sv
// Sample-in / sum-out handshake bundle for mavg3_window.
// sat_flag exists only when MAVG3_SAT_EN is defined.
interface mavg3_window_if #(
  parameter int DATA_W = 14
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_sum;
`ifdef MAVG3_SAT_EN
  logic              sat_flag;
`endif

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_sum
`ifdef MAVG3_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_sum
`ifdef MAVG3_SAT_EN
    , output sat_flag
`endif
  );
endinterface

// File: rtl/mavg3_window.sv
// Sliding 3-sample window sum (input to the div-by-3 stage), one output register.
// Optional MAVG3_SAT_EN: saturate sums above 16'hFFFF and add a sticky sat_flag.
module mavg3_window #(
  parameter int DATA_W = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  mavg3_window_if.slave  bus
);

  typedef enum logic [1:0] {W0, W1, W2, FULL} fill_t;

  fill_t             state_q, state_d;
  // The oldest sample leaves the window on the same shift that would store it,
  // so only the two most recent samples are ever needed for the next sum.
  logic [DATA_W-1:0] s0_q, s1_q;
  logic              out_valid_q;
  logic [15:0]       out_sum_q;
  logic              accept;
  logic              load;
  logic [15:0]       sum_val;

  // rst_n gates in_ready so upstream never sees a handshake while held in reset.
  assign bus.in_ready  = rst_n && !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;

`ifdef MAVG3_SAT_EN
  logic [17:0] sum_ext;
  logic        sat_hit;
  logic        sat_q;

  always_comb begin
    sum_ext = 18'(bus.in_data) + 18'(s0_q) + 18'(s1_q);
    sat_hit = |sum_ext[17:16];
    sum_val = sat_hit ? 16'hFFFF : sum_ext[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               sat_q <= 1'b0;
    else if (bus.flush)       sat_q <= 1'b0;
    else if (load && sat_hit) sat_q <= 1'b1;
  end

  assign bus.sat_flag = sat_q;
`else
  // Bits above 15 of the widened sum are discarded anyway, so a 16-bit add gives
  // the identical mod-2^16 result.
  assign sum_val = 16'(bus.in_data) + 16'(s0_q) + 16'(s1_q);
`endif

  // NOTE: every output of this block gets a default first; a path that leaves a
  // variable unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (bus.flush) begin
      state_d = W0;
    end else if (accept) begin
      unique case (state_q)
        W0:   state_d = W1;
        W1:   state_d = W2;
        W2:   begin state_d = FULL; load = 1'b1; end
        FULL: begin state_d = FULL; load = 1'b1; end
        default: state_d = W0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the sum above relies on pre-shift s0/s1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= W0;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
    end else if (bus.flush) begin
      s0_q <= '0;
      s1_q <= '0;
    end else if (accept) begin
      s1_q <= s0_q;
      s0_q <= bus.in_data;
    end
  end

  // Load wins over pop, which gives one result per clock when both happen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= 16'd0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= sum_val;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mavg3_window.sv
// Directed bench for mavg3_window: a DATA_W=14 instance for the main scenarios
// and a DATA_W=16 instance for the wrap / saturate boundary.
module tb_mavg3_window;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mavg3_window_if #(.DATA_W(14)) b14 ();
  mavg3_window_if #(.DATA_W(16)) b16 ();

  mavg3_window #(.DATA_W(14)) dut14 (.clk(clk), .rst_n(rst_n), .bus(b14));
  mavg3_window #(.DATA_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  task automatic push14(input logic [13:0] d);
    b14.in_valid = 1'b1;
    b14.in_data  = d;
    @(posedge clk); #1;
    b14.in_valid = 1'b0;
  endtask

  task automatic push16(input logic [15:0] d);
    b16.in_valid = 1'b1;
    b16.in_data  = d;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
  endtask

  task automatic idle14();
    b14.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b14.in_valid = 1'b0; b14.in_data = '0; b14.flush = 1'b0; b14.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_data = '0; b16.flush = 1'b0; b16.out_ready = 1'b1;
    #3;
    n_assert++;
    if (b14.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", b14.in_ready); end
    n_assert++;
    if (b14.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", b14.out_valid); end
    n_assert++;
    if (b14.out_sum !== 16'd0) begin n_fail++; $display("FAIL reset_out_sum: got %0d expected 0", b14.out_sum); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (b14.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", b14.in_ready); end
  endtask

  task automatic test_fill();
    push14(14'd3);
    push14(14'd21);
    n_assert++;
    if (b14.out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_no_early_output: got %b expected 0", b14.out_valid); end
    push14(14'd8);
    n_assert++;
    if (b14.out_valid !== 1'b1 || b14.out_sum !== 16'd32) begin
      n_fail++; $display("FAIL fill_first_sum: got v=%b sum=%0d expected v=1 sum=32", b14.out_valid, b14.out_sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_sum [3];
    logic [13:0] din [3];
    din = '{14'd0, 14'd1, 14'd2};
    exp_sum = '{16'd29, 16'd9, 16'd3};
    for (int i = 0; i < 3; i++) begin
      push14(din[i]);
      n_assert++;
      if (b14.out_valid !== 1'b1 || b14.out_sum !== exp_sum[i]) begin
        n_fail++; $display("FAIL b2b_sum[%0d]: got v=%b sum=%0d expected v=1 sum=%0d", i, b14.out_valid, b14.out_sum, exp_sum[i]);
      end
    end
    idle14();
    n_assert++;
    if (b14.out_valid !== 1'b0 || b14.out_sum !== 16'd3) begin
      n_fail++; $display("FAIL b2b_pop: got v=%b sum=%0d expected v=0 sum=3", b14.out_valid, b14.out_sum);
    end
  endtask

  task automatic test_stall();
    b14.flush = 1'b1;
    @(posedge clk); #1;
    b14.flush = 1'b0;
    push14(14'd5); push14(14'd5); push14(14'd5);
    n_assert++;
    if (b14.out_valid !== 1'b1 || b14.out_sum !== 16'd15) begin
      n_fail++; $display("FAIL stall_first: got v=%b sum=%0d expected v=1 sum=15", b14.out_valid, b14.out_sum);
    end
    b14.out_ready = 1'b0;
    b14.in_valid  = 1'b1;
    b14.in_data   = 14'd6;
    #1;
    n_assert++;
    if (b14.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", b14.in_ready); end
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if (b14.out_valid !== 1'b1 || b14.out_sum !== 16'd15 || b14.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold: got v=%b sum=%0d rdy=%b expected v=1 sum=15 rdy=0", b14.out_valid, b14.out_sum, b14.in_ready);
    end
    b14.out_ready = 1'b1;
    #1;
    n_assert++;
    if (b14.in_ready !== 1'b1 || b14.out_sum !== 16'd15) begin
      n_fail++; $display("FAIL stall_release: got rdy=%b sum=%0d expected rdy=1 sum=15", b14.in_ready, b14.out_sum);
    end
    @(posedge clk); #1;
    b14.in_valid = 1'b0;
    n_assert++;
    if (b14.out_valid !== 1'b1 || b14.out_sum !== 16'd16) begin
      n_fail++; $display("FAIL stall_next: got v=%b sum=%0d expected v=1 sum=16", b14.out_valid, b14.out_sum);
    end
    idle14();
  endtask

  task automatic test_flush();
    push14(14'd7);
    n_assert++;
    if (b14.out_valid !== 1'b1 || b14.out_sum !== 16'd18) begin
      n_fail++; $display("FAIL flush_pre_sum: got v=%b sum=%0d expected v=1 sum=18", b14.out_valid, b14.out_sum);
    end
    b14.out_ready = 1'b0;
    b14.flush     = 1'b1;
    b14.in_valid  = 1'b1;
    b14.in_data   = 14'd100;
    #1;
    n_assert++;
    if (b14.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", b14.in_ready); end
    @(posedge clk); #1;
    b14.flush    = 1'b0;
    b14.in_valid = 1'b0;
    n_assert++;
    if (b14.out_valid !== 1'b1 || b14.out_sum !== 16'd18) begin
      n_fail++; $display("FAIL flush_pending_kept: got v=%b sum=%0d expected v=1 sum=18", b14.out_valid, b14.out_sum);
    end
    b14.out_ready = 1'b1;
    idle14();
    push14(14'd2);
    push14(14'd2);
    n_assert++;
    if (b14.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_refill_early: got %b expected 0", b14.out_valid); end
    push14(14'd2);
    n_assert++;
    if (b14.out_valid !== 1'b1 || b14.out_sum !== 16'd6) begin
      n_fail++; $display("FAIL flush_refill_sum: got v=%b sum=%0d expected v=1 sum=6", b14.out_valid, b14.out_sum);
    end
`ifdef MAVG3_SAT_EN
    n_assert++;
    if (b14.sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_flag_idle14: got %b expected 0", b14.sat_flag); end
`endif
  endtask

  task automatic test_reset_mid();
    b14.flush = 1'b1;
    @(posedge clk); #1;
    b14.flush = 1'b0;
    push14(14'd4);
    push14(14'd4);
    b14.out_ready = 1'b0;
    push14(14'd4);
    n_assert++;
    if (b14.out_valid !== 1'b1 || b14.out_sum !== 16'd12) begin
      n_fail++; $display("FAIL midrst_pending: got v=%b sum=%0d expected v=1 sum=12", b14.out_valid, b14.out_sum);
    end
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if (b14.out_valid !== 1'b0 || b14.out_sum !== 16'd0 || b14.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: got v=%b sum=%0d rdy=%b expected v=0 sum=0 rdy=0", b14.out_valid, b14.out_sum, b14.in_ready);
    end
    b14.out_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    push14(14'd9);
    push14(14'd9);
    n_assert++;
    if (b14.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_refill_early: got %b expected 0", b14.out_valid); end
    push14(14'd9);
    n_assert++;
    if (b14.out_valid !== 1'b1 || b14.out_sum !== 16'd27) begin
      n_fail++; $display("FAIL midrst_refill_sum: got v=%b sum=%0d expected v=1 sum=27", b14.out_valid, b14.out_sum);
    end
  endtask

  task automatic test_wide_overflow();
    push16(16'hFFFF);
    push16(16'hFFFF);
    n_assert++;
    if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL wide_early: got %b expected 0", b16.out_valid); end
    push16(16'hFFFF);
`ifdef MAVG3_SAT_EN
    n_assert++;
    if (b16.out_valid !== 1'b1 || b16.out_sum !== 16'hFFFF || b16.sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL wide_saturate: got v=%b sum=%h flag=%b expected v=1 sum=ffff flag=1", b16.out_valid, b16.out_sum, b16.sat_flag);
    end
    b16.flush = 1'b1;
    @(posedge clk); #1;
    b16.flush = 1'b0;
    n_assert++;
    if (b16.sat_flag !== 1'b0) begin n_fail++; $display("FAIL wide_flag_clear: got %b expected 0", b16.sat_flag); end
`else
    n_assert++;
    if (b16.out_valid !== 1'b1 || b16.out_sum !== 16'hFFFD) begin
      n_fail++; $display("FAIL wide_wrap: got v=%b sum=%h expected v=1 sum=fffd", b16.out_valid, b16.out_sum);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_wide_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
